lagarto_reset_sequencer: RTL and testbench

Multi-hart reset and wake-up sequencer for the Lagarto tile. Generalises the single-core wake-up counter plus reset gating into `NumHarts` independent channels. Each channel gets:
- a staggered initial release,
- a per-hart soft-reset request/acknowledge handshake,
- a drain phase that waits for the hart's L1.5 traffic to go idle before asserting reset.

The block sits between the tile reset source and each core's `rstn_i`.

---
 rtl/lagarto_rstseq_pkg.sv | 17 +
 rtl/lagarto_rst_hart_fsm.sv | 124 ++++++++++++
 rtl/lagarto_reset_sequencer.sv | 69 ++++++
 tb/tb_lagarto_reset_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lagarto_rstseq_pkg.sv
// rtl/lagarto_rstseq_pkg.sv - shared state encoding and width helpers for the Lagarto reset sequencer
package lagarto_rstseq_pkg;

   typedef enum logic [2:0] {
      BOOT,
      RUN,
      DRAIN,
      HOLD,
      OFF
   } rstseq_state_e;

   // Bits needed to hold any value 0..max_val, never fewer than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lagarto_rst_hart_fsm.sv
// rtl/lagarto_rst_hart_fsm.sv - per-hart reset channel: boot release, soft-reset drain/hold, enable gating
// Optional drain timeout built when LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN is defined.
module lagarto_rst_hart_fsm
   import lagarto_rstseq_pkg::*;
#(
   parameter int unsigned HoldCycles   = 8,
   parameter int unsigned DrainTimeout = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic release_i,
   input  logic hart_en_i,
   input  logic soft_rst_req_i,
   input  logic hart_idle_i,
   output logic hart_rst_no,
   output logic soft_rst_ack_o,
   output logic drain_to_o,
   output logic run_o
);

   localparam int unsigned HoldW = cnt_width(HoldCycles);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

   rstseq_state_e    state_q;
   logic [HoldW-1:0] hold_cnt_q;
   logic             ack_arm_q;
   logic             skip_req_q;
   logic             rst_n_q;
   logic             ack_q;

`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
   localparam int unsigned DrainW = cnt_width(DrainTimeout);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);

   logic [DrainW-1:0] drain_cnt_q;
   logic              drain_to_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= BOOT;
         hold_cnt_q <= '0;
         ack_arm_q  <= 1'b0;
         skip_req_q <= 1'b0;
         rst_n_q    <= 1'b0;
         ack_q      <= 1'b0;
`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
         drain_cnt_q <= '0;
         drain_to_q  <= 1'b0;
`endif
      end else begin
         ack_q      <= 1'b0;
         skip_req_q <= 1'b0;
         case (state_q)
            BOOT: begin
               if (release_i) begin
                  state_q <= hart_en_i ? RUN : OFF;
                  rst_n_q <= hart_en_i;
               end
            end
            // The requester still holds the request in the ack cycle; skip it once.
            RUN: begin
               if (!hart_en_i || (soft_rst_req_i && !skip_req_q)) begin
                  state_q <= DRAIN;
`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
                  drain_cnt_q <= '0;
`endif
               end
            end
            DRAIN: begin
               if (hart_idle_i) begin
                  state_q    <= HOLD;
                  rst_n_q    <= 1'b0;
                  hold_cnt_q <= '0;
                  ack_arm_q  <= 1'b1;
`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
               end else if (drain_cnt_q == DrainLast) begin
                  state_q    <= HOLD;
                  rst_n_q    <= 1'b0;
                  hold_cnt_q <= '0;
                  ack_arm_q  <= 1'b1;
                  drain_to_q <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 1'b1;
`endif
               end
            end
            HOLD: begin
               if (hold_cnt_q == HoldLast) begin
                  ack_q      <= ack_arm_q;
                  skip_req_q <= 1'b1;
                  state_q    <= hart_en_i ? RUN : OFF;
                  rst_n_q    <= hart_en_i;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            // Re-enable goes through a silent HOLD so the hart sees a clean reset pulse.
            OFF: begin
               if (hart_en_i) begin
                  state_q    <= HOLD;
                  hold_cnt_q <= '0;
                  ack_arm_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= BOOT;
               rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign hart_rst_no    = rst_n_q;
   assign soft_rst_ack_o = ack_q;
   assign run_o          = (state_q == RUN);

`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
   assign drain_to_o = drain_to_q;
`else
   assign drain_to_o = 1'b0;
`endif

endmodule

// File: rtl/lagarto_reset_sequencer.sv
// rtl/lagarto_reset_sequencer.sv - multi-hart staggered reset release and soft-reset sequencer
// Drain timeout per hart enabled by LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN.
module lagarto_reset_sequencer
   import lagarto_rstseq_pkg::*;
#(
   parameter int unsigned NumHarts      = 4,
   parameter int unsigned WakeUpCycles  = 32768,
   parameter int unsigned StaggerCycles = 16,
   parameter int unsigned HoldCycles    = 8,
   parameter int unsigned DrainTimeout  = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumHarts-1:0] hart_en_i,
   input  logic [NumHarts-1:0] soft_rst_req_i,
   output logic [NumHarts-1:0] soft_rst_ack_o,
   input  logic [NumHarts-1:0] hart_idle_i,
   output logic [NumHarts-1:0] hart_rst_no,
   output logic [NumHarts-1:0] drain_to_o,
   output logic                all_run_o
);

   localparam int unsigned CntW = cnt_width(WakeUpCycles + NumHarts * StaggerCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(WakeUpCycles + (NumHarts - 1) * StaggerCycles);

   logic [CntW-1:0]     cnt_q;
   logic [NumHarts-1:0] run;
   logic                all_run_q;

   // Saturating at the last release point keeps every Tk reachable exactly once.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   for (genvar k = 0; k < NumHarts; k++) begin : g_hart
      localparam logic [CntW-1:0] RelCnt = CntW'(WakeUpCycles + k * StaggerCycles);

      lagarto_rst_hart_fsm #(
         .HoldCycles   (HoldCycles),
         .DrainTimeout (DrainTimeout)
      ) u_fsm (
         .clk_i          (clk_i),
         .rst_i          (rst_i),
         .release_i      (cnt_q == RelCnt),
         .hart_en_i      (hart_en_i[k]),
         .soft_rst_req_i (soft_rst_req_i[k]),
         .hart_idle_i    (hart_idle_i[k]),
         .hart_rst_no    (hart_rst_no[k]),
         .soft_rst_ack_o (soft_rst_ack_o[k]),
         .drain_to_o     (drain_to_o[k]),
         .run_o          (run[k])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         all_run_q <= 1'b0;
      end else begin
         all_run_q <= (|hart_en_i) & (&(run | ~hart_en_i));
      end
   end

   assign all_run_o = all_run_q;

endmodule

// File: tb/tb_lagarto_reset_sequencer.sv
// tb/tb_lagarto_reset_sequencer.sv - directed vector bench for lagarto_reset_sequencer (timeout cases under LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN)
module tb_lagarto_reset_sequencer;

   localparam int NH = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [NH-1:0] hart_en_i;
   logic [NH-1:0] soft_rst_req_i;
   logic [NH-1:0] soft_rst_ack_o;
   logic [NH-1:0] hart_idle_i;
   logic [NH-1:0] hart_rst_no;
   logic [NH-1:0] drain_to_o;
   logic          all_run_o;

   int cyc;
   int n_chk;
   int n_fail;

   always #5 clk = ~clk;

   lagarto_reset_sequencer #(
      .NumHarts      (NH),
      .WakeUpCycles  (64),
      .StaggerCycles (16),
      .HoldCycles    (8),
      .DrainTimeout  (32)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .hart_en_i      (hart_en_i),
      .soft_rst_req_i (soft_rst_req_i),
      .soft_rst_ack_o (soft_rst_ack_o),
      .hart_idle_i    (hart_idle_i),
      .hart_rst_no    (hart_rst_no),
      .drain_to_o     (drain_to_o),
      .all_run_o      (all_run_o)
   );

   typedef struct {
      int         cyc;
      logic [3:0] rst_no;
      logic       all_run;
   } vec_t;

   vec_t vecs[11];

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      soft_rst_req_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      cyc = 0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_i = 1'b1;
      hart_en_i = 4'b1111;
      soft_rst_req_i = '0;
      hart_idle_i = 4'b1111;

      vecs[0]  = '{0,   4'b0000, 1'b0};
      vecs[1]  = '{64,  4'b0000, 1'b0};
      vecs[2]  = '{65,  4'b0001, 1'b0};
      vecs[3]  = '{80,  4'b0001, 1'b0};
      vecs[4]  = '{81,  4'b0011, 1'b0};
      vecs[5]  = '{96,  4'b0011, 1'b0};
      vecs[6]  = '{97,  4'b0111, 1'b0};
      vecs[7]  = '{112, 4'b0111, 1'b0};
      vecs[8]  = '{113, 4'b1111, 1'b0};
      vecs[9]  = '{114, 4'b1111, 1'b1};
      vecs[10] = '{200, 4'b1111, 1'b1};

      // Staggered release, all harts enabled
      do_reset();
      chk("reset_ack", soft_rst_ack_o, 4'b0000);
      chk("reset_drain_to", drain_to_o, 4'b0000);
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].cyc - cyc);
         chk("release_rst_no", hart_rst_no, vecs[i].rst_no);
         chk("release_all_run", {3'b000, all_run_o}, {3'b000, vecs[i].all_run});
         chk("release_ack", soft_rst_ack_o, 4'b0000);
      end

      // Soft reset on hart 2 with idle held low for 20 cycles
      soft_rst_req_i[2] = 1'b1;
      hart_idle_i[2] = 1'b0;
      for (int c = 1; c <= 31; c++) begin
         step(1);
         chk("soft_rst_no", hart_rst_no, (c >= 21 && c <= 28) ? 4'b1011 : 4'b1111);
         chk("soft_ack", soft_rst_ack_o, (c == 29) ? 4'b0100 : 4'b0000);
         chk("soft_all_run", {3'b000, all_run_o}, {3'b000, !(c >= 2 && c <= 29)});
         chk("soft_drain_to", drain_to_o, 4'b0000);
         if (c == 20) hart_idle_i[2] = 1'b1;
         if (c == 30) soft_rst_req_i[2] = 1'b0;
      end

`ifdef LAGARTO_RSTSEQ_DRAIN_TIMEOUT_EN
      // Hart 2 times out; hart 3 sees idle in the same cycle as its timeout
      soft_rst_req_i[3:2] = 2'b11;
      hart_idle_i[3:2] = 2'b00;
      for (int c = 1; c <= 45; c++) begin
         step(1);
         chk("to_rst_no", hart_rst_no, (c >= 33 && c <= 40) ? 4'b0011 : 4'b1111);
         chk("to_drain_to", drain_to_o, (c >= 33) ? 4'b0100 : 4'b0000);
         chk("to_ack", soft_rst_ack_o, (c == 41) ? 4'b1100 : 4'b0000);
         if (c == 32) hart_idle_i[3] = 1'b1;
         if (c == 42) soft_rst_req_i[3:2] = 2'b00;
      end
      hart_idle_i = 4'b1111;
      soft_rst_req_i[2] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step(1);
         chk("to_sticky", drain_to_o, 4'b0100);
         chk("to_resoft_ack", soft_rst_ack_o, (c == 10) ? 4'b0100 : 4'b0000);
         if (c == 11) soft_rst_req_i[2] = 1'b0;
      end
`endif

      // Hart 1 enabled late: parks in OFF, then a silent HOLD
      hart_en_i = 4'b1101;
      do_reset();
      step(120);
      chk("late_off_rst_no", hart_rst_no, 4'b1101);
      chk("late_off_all_run", {3'b000, all_run_o}, 4'b0001);
      hart_en_i[1] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step(1);
         chk("late_rst_no", hart_rst_no, (c >= 9) ? 4'b1111 : 4'b1101);
         chk("late_ack", soft_rst_ack_o, 4'b0000);
         chk("late_all_run", {3'b000, all_run_o}, {3'b000, (c >= 10)});
      end

      // rst_i pulsed while hart 0 is in HOLD
      soft_rst_req_i[0] = 1'b1;
      step(4);
      chk("mid_hold_rst_no", hart_rst_no, 4'b1110);
      rst_i = 1'b1;
      soft_rst_req_i = '0;
      step(1);
      chk("mid_rst_rst_no", hart_rst_no, 4'b0000);
      chk("mid_rst_ack", soft_rst_ack_o, 4'b0000);
      chk("mid_rst_all_run", {3'b000, all_run_o}, 4'b0000);
      rst_i = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 82; c++) begin
         step(1);
         chk("restart_ack", soft_rst_ack_o, 4'b0000);
         if (c == 64) chk("restart_rst_no_64", hart_rst_no, 4'b0000);
         if (c == 65) chk("restart_rst_no_65", hart_rst_no, 4'b0001);
         if (c == 81) chk("restart_rst_no_81", hart_rst_no, 4'b0011);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
